audio_tone_gen: RTL and testbench

Parametrised multi-channel audio test-tone source for the HDMI output path, running entirely in the pixel clock domain. A fractional-N rate generator produces sample strobes at an exact average `SAMPLE_HZ` from `CLK_HZ`, which removes the derived audio clock. Each channel runs a phase accumulator with a selectable waveform. Samples are delivered through a one-entry valid/ready output register, with overrun counting.

---
 rtl/audio_tone_gen.sv | 79 +++++++
 tb/tb_audio_tone_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// Multi-channel HDMI audio test-tone source: a fractional-N sample strobe drives
// per-channel phase accumulators feeding a one-entry valid/ready output register.
module audio_tone_gen #(
  parameter int CLK_HZ    = 25_200_000,
  parameter int SAMPLE_HZ = 48_000,
  parameter int BIT_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int ACC_WIDTH = 32
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [3*CHANNELS-1:0]         mode,
  input  logic [BIT_WIDTH*CHANNELS-1:0] step,
  output logic [BIT_WIDTH*CHANNELS-1:0] sample_word,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [7:0]                    overrun_count
);

  localparam int W = BIT_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SAMPLE_INC = ACC_WIDTH'(SAMPLE_HZ);
  localparam logic [ACC_WIDTH-1:0] CLK_LIM    = ACC_WIDTH'(CLK_HZ);
  localparam logic [W-1:0] HALF   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SQ_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SQ_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic                  tick;
  logic [W-1:0]          phase  [CHANNELS];
  logic [W-1:0]          p_next [CHANNELS];
  logic [W-2:0]          tri_mag;
  logic [W*CHANNELS-1:0] wave_word;

  // acc always stays below CLK_HZ, so acc_sum cannot overflow ACC_WIDTH.
  assign acc_sum = acc + SAMPLE_INC;
  assign tick    = enable && (acc_sum >= CLK_LIM);

  always_comb begin
    wave_word = '0;
    tri_mag   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      p_next[c] = phase[c] + step[c*W +: W];
      tri_mag   = p_next[c][W-1] ? ~p_next[c][W-2:0] : p_next[c][W-2:0];
      case (mode[3*c +: 3])
        3'd1:    wave_word[c*W +: W] = p_next[c];
        3'd2:    wave_word[c*W +: W] = -p_next[c];
        3'd3:    wave_word[c*W +: W] = p_next[c][W-1] ? SQ_NEG : SQ_POS;
        3'd4:    wave_word[c*W +: W] = {tri_mag, 1'b0} ^ HALF;
        default: wave_word[c*W +: W] = '0;
      endcase
    end
  end

  // Handshake: a sample moves to the consumer on any cycle where sample_valid and
  // sample_ready are both high; a new sample replaces an unconsumed one (overrun).
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      acc           <= '0;
      sample_word   <= '0;
      sample_valid  <= 1'b0;
      overrun_count <= '0;
      for (int c = 0; c < CHANNELS; c++) phase[c] <= '0;
    end else begin
      if (enable) acc <= tick ? (acc_sum - CLK_LIM) : acc_sum;
      if (tick) begin
        for (int c = 0; c < CHANNELS; c++) phase[c] <= p_next[c];
        sample_word  <= wave_word;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready && overrun_count != 8'hFF)
          overrun_count <= overrun_count + 8'd1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen at CLK_HZ=10, SAMPLE_HZ=3: a cycle model feeds an expected
// queue that a negedge monitor drains on every transfer.
module tb_audio_tone_gen;
  localparam int C_HZ = 10;
  localparam int S_HZ = 3;
  localparam int W    = 16;
  localparam int CH   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [3*CH-1:0] mode = '0;
  logic [W*CH-1:0] step = '0;
  logic [W*CH-1:0] sample_word;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic [7:0]    overrun_count;

  audio_tone_gen #(
    .CLK_HZ(C_HZ), .SAMPLE_HZ(S_HZ), .BIT_WIDTH(W), .CHANNELS(CH), .ACC_WIDTH(32)
  ) dut (
    .clk_pixel(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .step(step),
    .sample_word(sample_word), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xfer_count = 0;
  bit running = 1'b0;

  logic [W*CH-1:0] exp_q[$];
  logic [W*CH-1:0] got_q[$];

  // Reference state: what the output register should hold after each edge.
  longint          m_n = 0;
  int unsigned     m_phase[CH];
  bit              m_valid = 1'b0;
  int              m_ovr = 0;
  logic [W*CH-1:0] m_word = '0;
  bit              cur_valid = 1'b0;
  int              cur_ovr = 0;
  logic [W*CH-1:0] cur_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] wave(input int m, input int unsigned p);
    int unsigned half = 1 << (W - 1);
    int unsigned full = 1 << W;
    int unsigned t;
    case (m)
      1: return W'(p);
      2: return W'((full - p) % full);
      3: return (p < half) ? W'(half - 1) : W'(full - (half - 1));
      4: begin
        t = (p < half) ? 2 * p : 2 * (full - 1 - p);
        return W'((t + half) % full);
      end
      default: return '0;
    endcase
  endfunction

  task automatic drive_cycle(input bit en, input bit rdy, input bit rn,
                             input logic [3*CH-1:0] md, input logic [W*CH-1:0] st);
    bit tk;
    bit xfer;
    logic [W*CH-1:0] w;
    @(posedge clk); #1;
    cur_valid = m_valid;
    cur_ovr   = m_ovr;
    cur_word  = m_word;
    enable = en; sample_ready = rdy; reset_n = rn; mode = md; step = st;
    if (!rn) begin
      m_n = 0; m_valid = 1'b0; m_ovr = 0; m_word = '0;
      for (int c = 0; c < CH; c++) m_phase[c] = 0;
      exp_q.delete();
      return;
    end
    xfer = m_valid && rdy;
    tk = 1'b0;
    if (en) begin
      m_n++;
      tk = ((m_n * S_HZ) / C_HZ) != (((m_n - 1) * S_HZ) / C_HZ);
    end
    if (tk) begin
      w = '0;
      for (int c = 0; c < CH; c++) begin
        m_phase[c] = (m_phase[c] + int'(st[c*W +: W])) % (1 << W);
        w[c*W +: W] = wave(int'(md[c*3 +: 3]), m_phase[c]);
      end
      if (m_valid && !rdy) begin
        exp_q[exp_q.size()-1] = w;
        if (m_ovr < 255) m_ovr++;
      end else begin
        exp_q.push_back(w);
      end
      m_valid = 1'b1;
      m_word  = w;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Runs from a fresh reset: mode 1 on ch0, mode 2 on ch1, step 600 on both.
  task automatic default_wave_check(input string tag);
    got_q.delete();
    drive_cycle(1'b1, 1'b1, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    check({tag, "_rst_word"}, sample_word, 32'h0);
    check({tag, "_rst_valid"}, {31'b0, sample_valid}, 32'h0);
    check({tag, "_rst_ovr"}, {24'b0, overrun_count}, 32'h0);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    @(negedge clk); #1;
    if (got_q.size() < 2) begin
      check({tag, "_sample_count"}, got_q.size(), 2);
    end else begin
      check({tag, "_first"}, got_q[0], 32'hFDA8_0258);
      check({tag, "_second"}, got_q[1], 32'hFB50_04B0);
    end
  endtask

  // Monitor: compares each presented transfer against the expected queue.
  initial begin
    logic [W*CH-1:0] e;
    forever begin
      @(negedge clk);
      if (running) begin
        check("valid", {31'b0, sample_valid}, {31'b0, cur_valid});
        check("overrun", {24'b0, overrun_count}, cur_ovr);
        if (!cur_valid) check("held_word", sample_word, cur_word);
        if (sample_valid && sample_ready) begin
          xfer_count++;
          got_q.push_back(sample_word);
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", sample_word, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("xfer_word", sample_word, e);
          end
        end
      end
    end
  end

  initial begin
    bit reached;
    logic [W*CH-1:0] gate_step;
    do_reset();
    do_reset();
    running = 1'b1;

    // Fractional rate: 300 transfers from 1000 enabled cycles.
    xfer_count = 0;
    for (int i = 0; i < 1001; i++)
      drive_cycle(1'b1, 1'b1, 1'b1, 6'($urandom_range(0, 63)), $urandom);
    @(negedge clk); #1;
    check("frac_xfers", xfer_count, 300);

    do_reset();
    default_wave_check("powerup");

    // Square on ch0, triangle on ch1, quarter-cycle step.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b1, 1'b1, {3'd4, 3'd3}, {16'h4000, 16'h4000});
    @(negedge clk); #1;
    if (got_q.size() < 4) begin
      check("sqtri_count", got_q.size(), 4);
    end else begin
      check("sqtri_0", got_q[0], 32'h0000_7FFF);
      check("sqtri_1", got_q[1], 32'h7FFE_8001);
      check("sqtri_2", got_q[2], 32'hFFFE_8001);
      check("sqtri_3", got_q[3], 32'h8000_7FFF);
    end
    got_q.delete();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 1'b1, {3'd7, 3'd5}, {16'h4000, 16'h4000});
    @(negedge clk); #1;
    check("reserved_count", {31'b0, got_q.size() >= 2}, 32'h1);
    foreach (got_q[i]) check("reserved_zero", got_q[i], 32'h0);
    got_q.delete();
    drive_cycle(1'b1, 1'b1, 1'b1, {3'd6, 3'd6}, {16'h4000, 16'h4000});
    drive_cycle(1'b1, 1'b1, 1'b1, {3'd6, 3'd6}, {16'h4000, 16'h4000});

    // Back-pressure: three ticks held off, then a single ready cycle.
    do_reset();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    drive_cycle(1'b1, 1'b1, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    check("bp_ovr", {24'b0, overrun_count}, 32'd2);
    check("bp_word", sample_word, 32'hF8F8_0708);
    drive_cycle(1'b1, 1'b0, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    check("bp_valid_fall", {31'b0, sample_valid}, 32'h0);

    // Reset mid-operation with five overruns pending.
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
      reached = (m_ovr == 5);
    end
    check("ovr5_reached", {31'b0, reached}, 32'h1);
    drive_cycle(1'b1, 1'b0, 1'b1, {3'd2, 3'd1}, {16'd600, 16'd600});
    check("pre_reset_valid", {31'b0, sample_valid}, 32'h1);
    do_reset();
    default_wave_check("midreset");

    // Random traffic with back-pressure and enable gaps.
    for (int i = 0; i < 3000; i++)
      drive_cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'b1,
                  6'($urandom_range(0, 63)), $urandom);

    // Forced overruns to saturation, then drain.
    for (int i = 0; i < 1100; i++)
      drive_cycle(1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 63)), $urandom);
    check("ovr_saturate", {24'b0, overrun_count}, 32'd255);
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b1, 1'b1, 1'b1, 6'($urandom_range(0, 63)), $urandom);

    // Enable gating mid-stream.
    gate_step = $urandom;
    for (int i = 0; i < 30; i++) drive_cycle(1'b1, 1'b1, 1'b1, {3'd2, 3'd1}, gate_step);
    for (int i = 0; i < 1000; i++)
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 6'($urandom_range(0, 63)), $urandom);
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b1, 1'b1, {3'd2, 3'd1}, gate_step);

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), m_valid ? 1 : 0);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
